// File: rtl/weight_sched_pkg.sv
// Shared definitions for the weight buffer ping-pong scheduler.
package weight_sched_pkg;

    localparam int BUFFER_NUM    = 32;
    localparam int ADDR_LEN      = 16;
    localparam int DATA_LEN      = 64;
    localparam int DDR_DATA_LEN  = 256;
    localparam int BPB           = DDR_DATA_LEN / DATA_LEN;
    localparam int GROUPS        = BUFFER_NUM / BPB;
    localparam int GRP_W         = $clog2(GROUPS);
    localparam int SET_W         = 8;
    localparam int WORDS_PER_SET = 9;
    localparam int BEAT_W        = 16;

    localparam logic [ADDR_LEN-1:0] SLOT_STRIDE   = {1'b1, {(ADDR_LEN-1){1'b0}}};
    localparam logic [BEAT_W-1:0]   BEATS_PER_SET = BEAT_W'(WORDS_PER_SET * GROUPS);

    typedef enum logic [1:0] {
        L_IDLE,
        L_WAIT,
        L_STREAM
    } ld_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CONF,
        R_WAIT
    } rd_state_t;

    // Base bank address of a ping-pong slot.
    function automatic logic [ADDR_LEN-1:0] slot_base(input logic slot);
        return slot ? SLOT_STRIDE : '0;
    endfunction

    // Word offset of a kernel set inside its slot: 9*s as (s<<3)+s.
    function automatic logic [ADDR_LEN-1:0] set_offset(input logic [SET_W-1:0] s);
        logic [ADDR_LEN-1:0] w;
        w = ADDR_LEN'(s);
        return (w << 3) + w;
    endfunction

endpackage

// File: rtl/weight_sched_ld.sv
// Load FSM: waits for a free slot, then streams DDR beats into it while
// generating per-bank write enables and word addresses.
module weight_sched_ld import weight_sched_pkg::*; (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ld_start,
    input  logic [SET_W-1:0]      i_ld_sets,
    input  logic                  i_ddr_valid,
    input  logic                  i_slot,
    input  logic                  i_slot_empty,
    output logic                  o_ld_busy,
    output logic                  o_ddr_ready,
    output logic [ADDR_LEN-1:0]   o_wr_addr,
    output logic [BUFFER_NUM-1:0] o_wr_en,
    output logic                  o_ld_done,
    output logic [SET_W-1:0]      o_ld_count
);

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic [SET_W-1:0]  r_sets;
    logic [BEAT_W-1:0] r_last;
    logic [BEAT_W-1:0] r_beat;
    logic              w_start;
    logic              w_hs;
    logic [GRP_W-1:0]  w_group;

    assign w_start    = (r_state == L_IDLE) && i_ld_start && (i_ld_sets != '0);
    assign w_hs       = (r_state == L_STREAM) && i_ddr_valid;
    assign w_group    = r_beat[GRP_W-1:0];
    assign o_ld_busy  = (r_state != L_IDLE);
    assign o_ld_count = r_sets;

    // State register, latched set count and beat counter (cleared while waiting for a slot).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= L_IDLE;
            r_sets  <= '0;
            r_last  <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_sets <= i_ld_sets;
                r_last <= BEAT_W'(i_ld_sets) * BEATS_PER_SET - BEAT_W'(1);
            end
            if (r_state == L_WAIT) begin
                r_beat <= '0;
            end else if (w_hs) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    // Next-state logic and the stream-side handshake/done outputs.
    always_comb begin
        w_next      = r_state;
        o_ddr_ready = 1'b0;
        o_ld_done   = 1'b0;
        case (r_state)
            L_IDLE: begin
                if (w_start) begin
                    w_next = L_WAIT;
                end
            end
            L_WAIT: begin
                if (i_slot_empty) begin
                    w_next = L_STREAM;
                end
            end
            L_STREAM: begin
                o_ddr_ready = 1'b1;
                if (w_hs && (r_beat == r_last)) begin
                    o_ld_done = 1'b1;
                    w_next    = L_IDLE;
                end
            end
            default: w_next = L_IDLE;
        endcase
    end

    // Bank write enables and address, only live during an accepted beat.
    always_comb begin
        o_wr_en   = '0;
        o_wr_addr = '0;
        if (w_hs) begin
            o_wr_en[int'(w_group)*BPB +: BPB] = {BPB{1'b1}};
            o_wr_addr = slot_base(i_slot) + ADDR_LEN'(r_beat >> GRP_W);
        end
    end

endmodule

// File: rtl/weight_sched.sv
// Ping-pong weight buffer scheduler: load side fills one slot while the
// read FSM serves kernel-set requests from the other.
module weight_sched import weight_sched_pkg::*; (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ld_start,
    input  logic [SET_W-1:0]      i_ld_sets,
    output logic                  o_ld_busy,
    input  logic                  i_ddr_valid,
    output logic                  o_ddr_ready,
    output logic [ADDR_LEN-1:0]   o_wr_addr,
    output logic [BUFFER_NUM-1:0] o_wr_en,
    output logic [1:0]            o_slot_full,
    input  logic                  i_rd_req,
    input  logic [SET_W-1:0]      i_rd_set,
    output logic                  o_rd_ack,
    output logic                  o_rd_done,
    output logic                  o_rd_err,
    input  logic                  i_rel,
    output logic                  o_buf_rd_conf,
    output logic [ADDR_LEN-1:0]   o_buf_st_rd_addr,
    input  logic                  i_buf_idle,
    input  logic                  i_buf_ker_en
);

    rd_state_t           r_rd_state;
    rd_state_t           w_rd_next;
    logic                r_wp;
    logic                r_rp;
    logic [1:0]          r_slot_full;
    logic [SET_W-1:0]    r_cnt [2];
    logic [ADDR_LEN-1:0] r_rd_addr;
    logic                w_accept;
    logic                w_rel;
    logic                w_ld_done;
    logic [SET_W-1:0]    w_ld_count;

    assign o_slot_full      = r_slot_full;
    assign o_buf_st_rd_addr = r_rd_addr;

    weight_sched_ld u_ld (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ld_start   (i_ld_start),
        .i_ld_sets    (i_ld_sets),
        .i_ddr_valid  (i_ddr_valid),
        .i_slot       (r_wp),
        .i_slot_empty (~r_slot_full[r_wp]),
        .o_ld_busy    (o_ld_busy),
        .o_ddr_ready  (o_ddr_ready),
        .o_wr_addr    (o_wr_addr),
        .o_wr_en      (o_wr_en),
        .o_ld_done    (w_ld_done),
        .o_ld_count   (w_ld_count)
    );

    // Read FSM state, latched start address and ping-pong slot bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state  <= R_IDLE;
            r_rd_addr   <= '0;
            r_wp        <= 1'b0;
            r_rp        <= 1'b0;
            r_slot_full <= 2'b00;
            r_cnt[0]    <= '0;
            r_cnt[1]    <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_accept) begin
                r_rd_addr <= slot_base(r_rp) + set_offset(i_rd_set);
            end
            if (w_rel) begin
                r_slot_full[r_rp] <= 1'b0;
                r_rp              <= ~r_rp;
            end
            if (w_ld_done) begin
                r_slot_full[r_wp] <= 1'b1;
                r_cnt[r_wp]       <= w_ld_count;
                r_wp              <= ~r_wp;
            end
        end
    end

    // Read next-state logic and its single-cycle handshake pulses.
    always_comb begin
        w_rd_next     = r_rd_state;
        o_rd_ack      = 1'b0;
        o_rd_err      = 1'b0;
        o_rd_done     = 1'b0;
        o_buf_rd_conf = 1'b0;
        w_accept      = 1'b0;
        w_rel         = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (i_rd_req && r_slot_full[r_rp]) begin
                    o_rd_ack = 1'b1;
                    if (i_rd_set < r_cnt[r_rp]) begin
                        w_accept  = 1'b1;
                        w_rd_next = R_CONF;
                    end else begin
                        o_rd_err = 1'b1;
                    end
                end
                w_rel = i_rel && r_slot_full[r_rp];
            end
            R_CONF: begin
                if (i_buf_idle) begin
                    o_buf_rd_conf = 1'b1;
                    w_rd_next     = R_WAIT;
                end
            end
            R_WAIT: begin
                if (i_buf_ker_en) begin
                    o_rd_done = 1'b1;
                    w_rd_next = R_IDLE;
                end
            end
            default: w_rd_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_weight_sched.sv
// Directed, table-driven bench for the weight buffer ping-pong scheduler.
module tb_weight_sched;

   logic        clk = 1'b0;
   logic        rstN;
   logic        ldStart;
   logic [7:0]  ldSets;
   logic        ldBusy;
   logic        ddrValid;
   logic        ddrReady;
   logic [15:0] wrAddr;
   logic [31:0] wrEn;
   logic [1:0]  slotFull;
   logic        rdReq;
   logic [7:0]  rdSet;
   logic        rdAck;
   logic        rdDone;
   logic        rdErr;
   logic        rel;
   logic        bufRdConf;
   logic [15:0] bufStRdAddr;
   logic        bufIdle;
   logic        bufKerEn;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          beat;
      logic [31:0] en;
      logic [15:0] offs;
   } beat_vec_t;

   typedef struct {
      logic [7:0]  set;
      logic [15:0] addr;
      logic        err;
   } rd_vec_t;

   beat_vec_t beatTab [6];
   rd_vec_t   rdTab [4];

   // 100 MHz bench clock
   always #5 clk = ~clk;

   weight_sched dut (
      .clk              (clk),
      .rst_n            (rstN),
      .i_ld_start       (ldStart),
      .i_ld_sets        (ldSets),
      .o_ld_busy        (ldBusy),
      .i_ddr_valid      (ddrValid),
      .o_ddr_ready      (ddrReady),
      .o_wr_addr        (wrAddr),
      .o_wr_en          (wrEn),
      .o_slot_full      (slotFull),
      .i_rd_req         (rdReq),
      .i_rd_set         (rdSet),
      .o_rd_ack         (rdAck),
      .o_rd_done        (rdDone),
      .o_rd_err         (rdErr),
      .i_rel            (rel),
      .o_buf_rd_conf    (bufRdConf),
      .o_buf_st_rd_addr (bufStRdAddr),
      .i_buf_idle       (bufIdle),
      .i_buf_ker_en     (bufKerEn)
   );

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Check the write enables/address of beats listed in the table
   task automatic checkBeat(input int beat, input logic [15:0] base);
      for (int i = 0; i < 6; i++) begin
         if (beatTab[i].beat == beat) begin
            checkOutput($sformatf("wr_en beat %0d", beat), wrEn, beatTab[i].en);
            checkOutput($sformatf("wr_addr beat %0d", beat), {16'h0, wrAddr}, {16'h0, base + beatTab[i].offs});
         end
      end
   endtask

   // Pulse ld_start with the given set count
   task automatic startLoad(input logic [7:0] sets);
      @(posedge clk); #1;
      ldStart = 1'b1;
      ldSets  = sets;
      @(posedge clk); #1;
      ldStart = 1'b0;
   endtask

   // Stream beats with ddr_valid held high; optionally stop inside beat stopBeat
   task automatic streamBeats(input logic [15:0] base, input int total, input int stopBeat);
      int got;
      int cycles;
      bit finished;
      got      = 0;
      cycles   = 0;
      finished = 1'b0;
      ddrValid = 1'b1;
      while (!finished) begin
         #1;
         if (ddrReady) begin
            checkBeat(got, base);
            if (got == stopBeat) finished = 1'b1;
            got++;
            if (got == total) finished = 1'b1;
         end
         cycles++;
         if (cycles > total + 40) finished = 1'b1;
         if (!finished) begin
            @(posedge clk); #1;
         end
      end
      if (stopBeat < 0) begin
         checkOutput("beat count", got, total);
      end
   endtask

   // Drop ddr_valid after a load and confirm the load side went idle
   task automatic endLoad();
      @(posedge clk); #1;
      ddrValid = 1'b0;
      #1;
      checkOutput("ld_busy after load", {31'h0, ldBusy}, 0);
      checkOutput("ddr_ready after load", {31'h0, ddrReady}, 0);
   endtask

   // Pulse rel for one cycle
   task automatic relPulse();
      @(posedge clk); #1;
      rel = 1'b1;
      @(posedge clk); #1;
      rel = 1'b0;
   endtask

   // One read request, with the buffer answering ker_en 10 cycles after rd_conf
   task automatic applyStimulus(input rd_vec_t v);
      int cycles;
      bit sawConf;
      @(posedge clk); #1;
      rdReq = 1'b1;
      rdSet = v.set;
      cycles = 0;
      #1;
      while (!rdAck && cycles < 20) begin
         @(posedge clk); #2;
         cycles++;
      end
      checkOutput($sformatf("rd_ack set %0d", v.set), {31'h0, rdAck}, 1);
      checkOutput($sformatf("rd_err set %0d", v.set), {31'h0, rdErr}, {31'h0, v.err});
      @(posedge clk); #1;
      rdReq = 1'b0;
      #1;
      if (!v.err) begin
         checkOutput($sformatf("buf_rd_conf set %0d", v.set), {31'h0, bufRdConf}, 1);
         checkOutput($sformatf("st_rd_addr set %0d", v.set), {16'h0, bufStRdAddr}, {16'h0, v.addr});
         repeat (10) @(posedge clk);
         #1;
         bufKerEn = 1'b1;
         #1;
         checkOutput($sformatf("rd_done set %0d", v.set), {31'h0, rdDone}, 1);
         @(posedge clk); #1;
         bufKerEn = 1'b0;
      end else begin
         sawConf = 1'b0;
         repeat (5) begin
            if (bufRdConf) sawConf = 1'b1;
            @(posedge clk); #2;
         end
         checkOutput($sformatf("no conf set %0d", v.set), {31'h0, sawConf}, 0);
      end
   endtask

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence
   initial begin
      rd_vec_t v;
      bit sawReady;

      beatTab[0] = '{0,   32'h0000_000F, 16'd0};
      beatTab[1] = '{9,   32'h0000_00F0, 16'd1};
      beatTab[2] = '{30,  32'h0F00_0000, 16'd3};
      beatTab[3] = '{71,  32'hF000_0000, 16'd8};
      beatTab[4] = '{72,  32'h0000_000F, 16'd9};
      beatTab[5] = '{143, 32'hF000_0000, 16'd17};

      rdTab[0] = '{8'd1, 16'h8009, 1'b0};
      rdTab[1] = '{8'd3, 16'h0000, 1'b1};
      rdTab[2] = '{8'd2, 16'h0000, 1'b1};
      rdTab[3] = '{8'd0, 16'h8000, 1'b0};

      rstN = 1'b0; ldStart = 1'b0; ldSets = 8'd0; ddrValid = 1'b0;
      rdReq = 1'b0; rdSet = 8'd0; rel = 1'b0; bufIdle = 1'b1; bufKerEn = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset ld_busy", {31'h0, ldBusy}, 0);
      checkOutput("reset ddr_ready", {31'h0, ddrReady}, 0);
      checkOutput("reset wr_en", wrEn, 0);
      checkOutput("reset wr_addr", {16'h0, wrAddr}, 0);
      checkOutput("reset slot_full", {30'h0, slotFull}, 0);
      checkOutput("reset rd pulses", {29'h0, rdAck, rdDone, rdErr}, 0);
      checkOutput("reset buf_rd_conf", {31'h0, bufRdConf}, 0);
      checkOutput("reset st_rd_addr", {16'h0, bufStRdAddr}, 0);
      rstN = 1'b1;

      // One set into slot 0
      startLoad(8'd1);
      streamBeats(16'h0000, 72, -1);
      endLoad();
      checkOutput("slot_full after load 0", {30'h0, slotFull}, 2'b01);

      // Read set 0, then the boundary rd_set == count
      v = '{8'd0, 16'h0000, 1'b0};
      applyStimulus(v);
      v = '{8'd1, 16'h0000, 1'b1};
      applyStimulus(v);

      // Two sets into slot 1 while slot 0 is being read
      fork
         begin
            startLoad(8'd2);
            streamBeats(16'h8000, 144, -1);
         end
         begin
            repeat (3) @(posedge clk);
            v = '{8'd0, 16'h0000, 1'b0};
            applyStimulus(v);
         end
      join
      endLoad();
      checkOutput("slot_full both", {30'h0, slotFull}, 2'b11);

      // Both full: load waits for rel, then streams into slot 0
      startLoad(8'd1);
      ddrValid = 1'b1;
      sawReady = 1'b0;
      repeat (5) begin
         #1;
         if (ddrReady) sawReady = 1'b1;
         @(posedge clk); #1;
      end
      #1;
      checkOutput("ld_busy while waiting", {31'h0, ldBusy}, 1);
      checkOutput("ddr_ready while waiting", {31'h0, sawReady}, 0);
      relPulse();
      streamBeats(16'h0000, 72, -1);
      endLoad();
      checkOutput("slot_full refill", {30'h0, slotFull}, 2'b11);

      // Table of reads against the 2-set slot 1
      for (int i = 0; i < 4; i++) begin
         applyStimulus(rdTab[i]);
      end

      // Release slot 1, start a load into it and reset during beat 30
      relPulse();
      #1;
      checkOutput("slot_full after rel", {30'h0, slotFull}, 2'b01);
      startLoad(8'd1);
      streamBeats(16'h8000, 72, 30);
      rstN = 1'b0;
      @(posedge clk); #1;
      checkOutput("mid reset ld_busy", {31'h0, ldBusy}, 0);
      checkOutput("mid reset ddr_ready", {31'h0, ddrReady}, 0);
      checkOutput("mid reset wr_en", wrEn, 0);
      checkOutput("mid reset wr_addr", {16'h0, wrAddr}, 0);
      checkOutput("mid reset slot_full", {30'h0, slotFull}, 0);
      checkOutput("mid reset st_rd_addr", {16'h0, bufStRdAddr}, 0);
      ddrValid = 1'b0;
      rstN = 1'b1;

      // Next load lands in slot 0 again
      startLoad(8'd1);
      streamBeats(16'h0000, 72, -1);
      endLoad();
      checkOutput("slot_full after reset load", {30'h0, slotFull}, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_sched.md
# weight_sched

Ping-pong load/read scheduler for the on-chip weight buffer. It streams 256-bit DDR beats into one slot of the buffer, generating the per-bank write enables and addresses. In parallel, it serves kernel-set read requests from the PE-array controller out of the other, already-filled slot by pulsing the buffer's read-configure. Sits between the DDR weight reader, the weight buffer and the layer controller.

## Interface
- BUFFER_NUM, 32, number of 64-bit weight banks
- ADDR_LEN, 16, bank address width
- DATA_LEN, 64, bank word width
- DDR_DATA_LEN, 256, DDR beat width; BPB = DDR_DATA_LEN/DATA_LEN banks are written per beat
- GROUPS, BUFFER_NUM/BPB (8), beats per bank word row
- SET_W, 8, width of kernel-set count/index
- SLOT_STRIDE, 2**(ADDR_LEN-1), base address of slot 1 (slot 0 base = 0)
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- ld_start  in  1  pulse: load ld_sets kernel sets into the next free slot
- ld_sets  in  SET_W  kernel sets to load, sampled on ld_start
- ld_busy  out  1  load in progress (including waiting for a free slot)
- ddr_valid  in  1  DDR beat available
- ddr_ready  out  1  beat accepted when ddr_valid & ddr_ready
- wr_addr  out  ADDR_LEN  buffer write address
- wr_en  out  BUFFER_NUM  buffer write enables
- slot_full  out  2  slot holds a complete load
- rd_req  in  1  request one kernel set, held until rd_ack
- rd_set  in  SET_W  set index within the current read slot
- rd_ack  out  1  one-cycle pulse: request accepted
- rd_done  out  1  one-cycle pulse: kernels valid at the buffer output
- rd_err  out  1  one-cycle pulse: rd_set >= sets in the slot; request dropped
- rel  in  1  pulse: release the current read slot
- buf_rd_conf  out  1  to buffer rd_conf
- buf_st_rd_addr  out  ADDR_LEN  to buffer st_rd_addr
- buf_idle  in  1  from buffer idle
- buf_ker_en  in  1  from buffer ker_en

## Operation
- Kernel set = 9 consecutive words per bank. Set s in slot n occupies base(n) + 9*s … +8. 9*s is computed as (s<<3)+s, truncated to ADDR_LEN.
- Load FSM:
  - L_IDLE: on ld_start with ld_sets != 0, latch the count and go to L_WAIT. ld_sets == 0 is ignored. ld_start while not in L_IDLE is ignored.
  - L_WAIT: the target is the write pointer slot. Stay until that slot is empty, then go to L_STREAM with the beat counter at 0.
  - L_STREAM: ddr_ready = 1. For beat b: group g = b mod GROUPS, word w = b / GROUPS. On a handshake, wr_addr = base + w and wr_en bits [g*BPB +: BPB] = 1; all other bits are 0. After 9*GROUPS*ld_sets beats, set slot_full[slot], store the set count in that slot, toggle the write pointer, and return to L_IDLE.
- Read FSM:
  - R_IDLE: if rd_req and the read pointer slot is full: when rd_set < the slot count, pulse rd_ack and go to R_CONF; otherwise pulse rd_ack and rd_err, and stay.
  - R_CONF: wait for buf_idle, then assert buf_rd_conf for one cycle with buf_st_rd_addr = base + 9*rd_set, and go to R_WAIT.
  - R_WAIT: on buf_ker_en, rd_done = 1 (same cycle, combinational), and return to R_IDLE.
- rel (accepted only in R_IDLE) clears slot_full[read pointer] and toggles the read pointer. rel with the slot not full is ignored.
- A slot's load completion and a rel of the other slot in the same cycle are both applied.

## Timing
- Reset values: ld_busy 0, ddr_ready 0, wr_en 0, wr_addr 0, slot_full 00, rd_ack/rd_done/rd_err 0, buf_rd_conf 0, buf_st_rd_addr 0. Both pointers reset to slot 0.
- Reset mid-operation aborts both FSMs and empties both slots. Partially written data is abandoned.
- wr_en and wr_addr are combinational with the handshake (same cycle as ddr_valid & ddr_ready).
- rd_req to buf_rd_conf is 2 cycles minimum (ack, then conf). buf_rd_conf to rd_done is 10 cycles, set by the buffer.
- A load of N sets takes at least 72*N cycles at full ddr_valid.

## Structure
- Shared package: state encodings, WORDS_PER_SET = 9, and a slot-base function.
- One natural sub-module: weight_sched_ld (load FSM plus address/enable generator). The read FSM and slot bookkeeping live in the top.

## Test plan
- Load 1 set with continuous valid → 72 beats. Beat 0: wr_en = 0x0000000F, wr_addr 0. Beat 9: wr_en = 0x000000F0, wr_addr 1. slot_full = 01.
- rd_req with set 0 → rd_ack, then buf_rd_conf with address 0. Model ker_en 10 cycles later → rd_done the same cycle.
- Load 2 sets into slot 1 while reading slot 0 → slot 1 writes start at 0x8000. After rel, a read of set 1 gives buf_st_rd_addr 0x8009.
- Both slots full, ld_start → ld_busy=1 and ddr_ready=0 until rel, then streaming begins into slot 0.
- rd_req with rd_set=3 on a 2-set slot → rd_ack and rd_err pulse, no buf_rd_conf.
- rst_n low during beat 30 of a load → all outputs at reset values, slot_full=00, and the next load starts at address 0.
